ps2_mem_editor: RTL and testbench
=================================

PS2_MEM_EDITOR -- requirements
Module: ps2_mem_editor

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000: memoryCLK cycles without a PS/2 falling edge before a partial frame is discarded.
REQ-002 Parameter ADDR_W, default 12: address width.
REQ-003 memoryCLK  in  1  sole clock; all logic on the rising edge.
REQ-004 rst_n  in  1  synchronous reset, active-low, sampled on the rising edge of memoryCLK.
REQ-005 ps2_clk  in  1  raw PS/2 keyboard clock, asynchronous.
REQ-006 ps2_data  in  1  raw PS/2 keyboard data, asynchronous.
REQ-007 Adress  out  ADDR_W  memory address driven into the RAM port.
REQ-008 DataIN  out  8  byte to write into RAM.
REQ-009 WE  out  1  one-cycle write strobe, active-high.
REQ-010 pending  out  1  high nibble entered, low nibble awaited.
REQ-011 frame_err  out  1  one-cycle pulse on a parity, stop-bit or timeout error.

Function
REQ-012 ps2_clk and ps2_data each SHALL pass through a 2-flop synchronizer; a falling edge is sync_clk high one cycle, then low the next.
REQ-013 Receiver FSM states: RX_IDLE, RX_DATA, RX_PARITY, RX_STOP; each transition advances only on a detected falling edge.
REQ-014 RX_IDLE: data 0 -> RX_DATA; data 1 -> stay in RX_IDLE with no error.
REQ-015 RX_DATA: shift in 8 bits LSB first; after the 8th bit -> RX_PARITY.
REQ-016 RX_PARITY: capture the bit; odd parity over the 8 data bits plus the parity bit is required.
REQ-017 RX_STOP: stop=1 and parity good -> one-cycle code_valid with the byte; otherwise pulse frame_err and discard the byte; in all cases -> RX_IDLE.
REQ-018 Timeout: in any state other than RX_IDLE, TIMEOUT_CYCLES cycles without an edge -> RX_IDLE plus a frame_err pulse; the counter clears on every edge.
REQ-019 Decoder flags: byte F0 sets brk; byte E0 sets ext; the next non-prefix byte is consumed and then clears both flags.
REQ-020 A byte with brk set (key release) SHALL be ignored.
REQ-021 Make codes, scan set 2: 0=45, 1=16, 2=1E, 3=26, 4=25, 5=2E, 6=36, 7=3D, 8=3E, 9=46, A=1C, B=32, C=21, D=23, E=24, F=2B.
REQ-022 Extended make codes: left=6B (Adress-1), right=74 (Adress+1), up=75 (Adress-16), down=72 (Adress+16); arithmetic modulo 2^ADDR_W.
REQ-023 Non-extended 76 (Esc) SHALL clear pending without writing.
REQ-024 Any other code SHALL be ignored.
REQ-025 Editor FSM states: ED_HI, ED_LO, ED_WR.
REQ-026 ED_HI + hex key: latch DataIN[7:4], set pending -> ED_LO.
REQ-027 ED_LO + hex key: latch DataIN[3:0] -> ED_WR.
REQ-028 ED_WR: WE=1 for exactly one cycle with the current Adress and DataIN; next cycle Adress+1 (FFF wraps to 000), pending=0 -> ED_HI.
REQ-029 An arrow key in ED_LO SHALL move the address and keep the pending nibble.
REQ-030 Esc in ED_LO -> ED_HI with no write.
REQ-031 Adress and DataIN SHALL be stable whenever WE=1; WE SHALL never be high on two consecutive cycles.
REQ-032 Latency: the final falling edge (stop bit) to the code_valid cycle is 3 memoryCLK cycles; for a write, code_valid to WE is 2 cycles.

Reset
REQ-033 rst_n=0: Adress=0, DataIN=00, WE=0, pending=0, frame_err=0, both FSMs in IDLE/ED_HI, brk=ext=0, timeout counter=0, synchronizers=1.
REQ-034 Reset asserted mid-frame or mid-entry SHALL abandon the operation with no WE pulse.

Structure
REQ-035 Scan-code constants, state encodings and ADDR_W default SHALL live in shared package ps2_pkg.
REQ-036 The frame receiver (REQ-012..018) SHALL be sub-module ps2_rx, which outputs code_valid, code and frame_err.

Verification
REQ-037 Frames 1E, 2B at a 12 kHz PS/2 clock, Adress=000 -> one WE with Adress=000, DataIN=2F; then Adress=001.
REQ-038 Frame with a bad parity bit -> frame_err pulses once; no state change; next good frame is decoded normally.
REQ-039 Adress=FFF, keys 45, 45 -> WE with DataIN=00 at FFF; Adress wraps to 000.
REQ-040 Sequence E0 75 from Adress=005 -> Adress=FF5; sequence F0 1E -> nothing written, pending unchanged.
REQ-041 Key 16, then Esc (76), then 26 -> pending=1 and no WE; 26's nibble is the new high nibble.
REQ-042 ps2_clk held low after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse; the following full frame 45 is accepted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 memory editor: scan codes, FSM encodings,
// default address width and the hex-key lookup.
package ps2_pkg;

    localparam int ADDR_W_DEF = 12;

    // Receiver and editor state encodings
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        ED_HI = 2'd0,
        ED_LO = 2'd1,
        ED_WR = 2'd2
    } ed_state_t;

    // Prefix bytes
    localparam logic [7:0] CODE_BRK = 8'hF0;
    localparam logic [7:0] CODE_EXT = 8'hE0;

    // Non-extended control key
    localparam logic [7:0] KEY_ESC = 8'h76;

    // Extended arrow keys
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;

    // Hex digit make codes, scan set 2
    localparam logic [7:0] KEY_0 = 8'h45;
    localparam logic [7:0] KEY_1 = 8'h16;
    localparam logic [7:0] KEY_2 = 8'h1E;
    localparam logic [7:0] KEY_3 = 8'h26;
    localparam logic [7:0] KEY_4 = 8'h25;
    localparam logic [7:0] KEY_5 = 8'h2E;
    localparam logic [7:0] KEY_6 = 8'h36;
    localparam logic [7:0] KEY_7 = 8'h3D;
    localparam logic [7:0] KEY_8 = 8'h3E;
    localparam logic [7:0] KEY_9 = 8'h46;
    localparam logic [7:0] KEY_A = 8'h1C;
    localparam logic [7:0] KEY_B = 8'h32;
    localparam logic [7:0] KEY_C = 8'h21;
    localparam logic [7:0] KEY_D = 8'h23;
    localparam logic [7:0] KEY_E = 8'h24;
    localparam logic [7:0] KEY_F = 8'h2B;

    // Returns {is_hex, nibble}; is_hex=0 for any non-digit code
    function automatic logic [4:0] hex_lookup(input logic [7:0] code);
        logic [4:0] r;
        r = 5'h00;
        case (code)
            KEY_0: r = {1'b1, 4'h0};
            KEY_1: r = {1'b1, 4'h1};
            KEY_2: r = {1'b1, 4'h2};
            KEY_3: r = {1'b1, 4'h3};
            KEY_4: r = {1'b1, 4'h4};
            KEY_5: r = {1'b1, 4'h5};
            KEY_6: r = {1'b1, 4'h6};
            KEY_7: r = {1'b1, 4'h7};
            KEY_8: r = {1'b1, 4'h8};
            KEY_9: r = {1'b1, 4'h9};
            KEY_A: r = {1'b1, 4'hA};
            KEY_B: r = {1'b1, 4'hB};
            KEY_C: r = {1'b1, 4'hC};
            KEY_D: r = {1'b1, 4'hD};
            KEY_E: r = {1'b1, 4'hE};
            KEY_F: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the raw keyboard lines, detects falling
// edges of the PS/2 clock and assembles 11-bit frames into scan-code bytes.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       memoryCLK,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       code_valid,
    output logic [7:0] code,
    output logic       frame_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic            clk_p0, clk_p1, clk_p2;
    logic            dat_p0, dat_p1;
    logic            fall;
    rx_state_t       state;
    logic [2:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic            par_ok;

    // clk_p2 holds the previous synchronized level, so a fall is high-then-low
    assign fall   = clk_p2 & ~clk_p1;
    assign par_ok = ^{shreg, par_bit};

    // Two-flop synchronizers for both lines plus the edge-detect history flop
    always_ff @(posedge memoryCLK) begin
        if (!rst_n) begin
            clk_p0 <= 1'b1;
            clk_p1 <= 1'b1;
            clk_p2 <= 1'b1;
            dat_p0 <= 1'b1;
            dat_p1 <= 1'b1;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            clk_p2 <= clk_p1;
            dat_p0 <= ps2_data;
            dat_p1 <= dat_p0;
        end
    end

    // Data bits shift in LSB first; the parity bit is captured for the stop check
    always_ff @(posedge memoryCLK) begin
        if (fall && state == RX_DATA) begin
            shreg <= {dat_p1, shreg[7:1]};
        end
        if (fall && state == RX_PARITY) begin
            par_bit <= dat_p1;
        end
        if (fall && state == RX_STOP) begin
            code <= shreg;
        end
    end

    // Frame FSM with inactivity timeout; outputs are single-cycle pulses
    always_ff @(posedge memoryCLK) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            to_cnt     <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == RX_IDLE || fall) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                // A stalled partial frame is dropped and reported
                state     <= RX_IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!dat_p1) begin
                            state   <= RX_DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    RX_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        if (dat_p1 && par_ok) begin
                            code_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_mem_editor.sv
// Keyboard-driven memory editor: two hex keys form a byte that is written at
// the current address, arrow keys move the address and Esc abandons an entry.
module ps2_mem_editor
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ADDR_W         = ADDR_W_DEF
) (
    input  logic              memoryCLK,
    input  logic              rst_n,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [ADDR_W-1:0] Adress,
    output logic [7:0]        DataIN,
    output logic              WE,
    output logic              pending,
    output logic              frame_err
);

    logic       code_valid;
    logic [7:0] code;
    logic [4:0] hex;
    logic       brk;
    logic       ext;
    ed_state_t  ed_state;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .memoryCLK (memoryCLK),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .code_valid(code_valid),
        .code      (code),
        .frame_err (frame_err)
    );

    assign hex = hex_lookup(code);

    // Prefix tracking, key decode and the nibble-entry / write sequencer
    always_ff @(posedge memoryCLK) begin
        if (!rst_n) begin
            ed_state <= ED_HI;
            Adress   <= '0;
            DataIN   <= 8'h00;
            WE       <= 1'b0;
            pending  <= 1'b0;
            brk      <= 1'b0;
            ext      <= 1'b0;
        end else begin
            WE <= 1'b0;

            // Write strobe for one cycle, then advance the address the cycle after
            if (ed_state == ED_WR) begin
                if (!WE) begin
                    WE <= 1'b1;
                end else begin
                    Adress   <= Adress + ADDR_W'(1);
                    pending  <= 1'b0;
                    ed_state <= ED_HI;
                end
            end

            if (code_valid) begin
                if (code == CODE_BRK) begin
                    brk <= 1'b1;
                end else if (code == CODE_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    // Releases are dropped; codes arriving mid-write are dropped too
                    if (!brk && ed_state != ED_WR) begin
                        if (ext) begin
                            case (code)
                                KEY_LEFT:  Adress <= Adress - ADDR_W'(1);
                                KEY_RIGHT: Adress <= Adress + ADDR_W'(1);
                                KEY_UP:    Adress <= Adress - ADDR_W'(16);
                                KEY_DOWN:  Adress <= Adress + ADDR_W'(16);
                                default:   ;
                            endcase
                        end else if (hex[4]) begin
                            if (ed_state == ED_HI) begin
                                DataIN[7:4] <= hex[3:0];
                                pending     <= 1'b1;
                                ed_state    <= ED_LO;
                            end else begin
                                DataIN[3:0] <= hex[3:0];
                                ed_state    <= ED_WR;
                            end
                        end else if (code == KEY_ESC) begin
                            pending  <= 1'b0;
                            ed_state <= ED_HI;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_mem_editor.sv
// Bench for ps2_mem_editor: PS/2 frames are bit-banged into the DUT, expected
// writes and frame errors go into a queue, and a monitor pops them as they occur.
`timescale 1ns/1ps
module tb_ps2_mem_editor;

    localparam int TO   = 300;
    localparam int HALF = 20;
    localparam int GAP  = 60;

    logic        memoryCLK = 1'b0;
    logic        rst_n     = 1'b0;
    logic        ps2_clk   = 1'b1;
    logic        ps2_data  = 1'b1;
    logic [11:0] Adress;
    logic [7:0]  DataIN;
    logic        WE;
    logic        pending;
    logic        frame_err;

    typedef struct packed {
        logic        is_err;
        logic [11:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic prev_we = 1'b0;

    ps2_mem_editor #(
        .TIMEOUT_CYCLES(TO),
        .ADDR_W        (12)
    ) dut (
        .memoryCLK(memoryCLK),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .Adress   (Adress),
        .DataIN   (DataIN),
        .WE       (WE),
        .pending  (pending),
        .frame_err(frame_err)
    );

    always #5 memoryCLK = ~memoryCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge memoryCLK);
        #1;
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [7:0] d);
        exp_q.push_back('{is_err: 1'b0, addr: a, data: d});
    endtask

    task automatic push_err();
        exp_q.push_back('{is_err: 1'b1, addr: 12'h000, data: 8'h00});
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(GAP);
    endtask

    task automatic key(input logic [7:0] b);
        send_frame(b, 1'b0);
    endtask

    task automatic ext_key(input logic [7:0] b);
        key(8'hE0);
        key(b);
    endtask

    // Start bit plus ndata data bits; the clock stays low for hold cycles after the last one
    task automatic send_partial(input logic [7:0] b, input int ndata, input int hold);
        ps2_data = 1'b0;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
        for (int i = 0; i < ndata; i++) begin
            ps2_data = b[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick((i == ndata - 1) ? hold : HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_state(input string name, input logic [11:0] a, input logic p);
        @(negedge memoryCLK);
        check({name, "_addr"}, 32'(Adress), 32'(a));
        check({name, "_pending"}, 32'(pending), 32'(p));
    endtask

    // Monitor: every WE or frame_err must match the head of the expected queue
    always @(negedge memoryCLK) begin
        ev_t e;
        if (WE && prev_we) begin
            n_cmp++;
            n_bad++;
            $display("FAIL we_back_to_back: WE high on consecutive cycles, required single-cycle");
        end
        if (WE || frame_err) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: WE=%0b frame_err=%0b Adress=%0h DataIN=%0h, required no event",
                         WE, frame_err, Adress, DataIN);
            end else begin
                e = exp_q.pop_front();
                check("event_is_err", 32'(frame_err), 32'(e.is_err));
                if (!e.is_err) begin
                    check("wr_addr", 32'(Adress), 32'(e.addr));
                    check("wr_data", 32'(DataIN), 32'(e.data));
                end
            end
        end
        prev_we = WE;
    end

    initial begin
        // Reset values
        tick(5);
        @(negedge memoryCLK);
        check("rst_addr", 32'(Adress), 32'h000);
        check("rst_data", 32'(DataIN), 32'h00);
        check("rst_we", 32'(WE), 32'h0);
        check("rst_pending", 32'(pending), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(10);
        check_state("post_rst", 12'h000, 1'b0);

        // 1E then 2B writes 2F at 000
        key(8'h1E);
        check_state("hi_2", 12'h000, 1'b1);
        push_wr(12'h000, 8'h2F);
        key(8'h2B);
        check_state("after_2f", 12'h001, 1'b0);

        // Bad parity frame is reported and otherwise ignored
        push_err();
        send_frame(8'h16, 1'b1);
        check_state("bad_par", 12'h001, 1'b0);

        // 16, Esc, 26: the 3 becomes the new high nibble
        key(8'h16);
        check_state("hi_1", 12'h001, 1'b1);
        key(8'h76);
        check_state("esc", 12'h001, 1'b0);
        key(8'h26);
        check_state("hi_3", 12'h001, 1'b1);
        push_wr(12'h001, 8'h37);
        key(8'h3D);
        check_state("after_37", 12'h002, 1'b0);

        // Left x3 from 002 wraps to FFF; 00 written there, address wraps to 000
        for (int i = 0; i < 3; i++) ext_key(8'h6B);
        check_state("left_wrap", 12'hFFF, 1'b0);
        key(8'h45);
        push_wr(12'hFFF, 8'h00);
        key(8'h45);
        check_state("after_fff", 12'h000, 1'b0);

        // Right x5 to 005, then up wraps to FF5
        for (int i = 0; i < 5; i++) ext_key(8'h74);
        check_state("right5", 12'h005, 1'b0);
        ext_key(8'h75);
        check_state("up_wrap", 12'hFF5, 1'b0);

        // Release of 2 is ignored while a nibble is pending
        key(8'h25);
        key(8'hF0);
        key(8'h1E);
        check_state("break_ign", 12'hFF5, 1'b1);
        check("break_data", 32'(DataIN), 32'h40);

        // Arrow in low-nibble state moves the address and keeps the nibble
        ext_key(8'h74);
        check_state("arrow_lo", 12'hFF6, 1'b1);
        push_wr(12'hFF6, 8'h45);
        key(8'h2E);
        check_state("after_45", 12'hFF7, 1'b0);

        // Clock stuck low mid-frame times out; next frame decodes normally
        push_err();
        send_partial(8'h45, 4, TO + 50);
        tick(GAP);
        check_state("timeout", 12'hFF7, 1'b0);
        key(8'h45);
        check_state("post_to", 12'hFF7, 1'b1);
        push_wr(12'hFF7, 8'h00);
        key(8'h45);
        check_state("after_ff7", 12'hFF8, 1'b0);

        // Reset mid-entry and mid-frame abandons everything without a write
        key(8'h16);
        check_state("pre_rst", 12'hFF8, 1'b1);
        send_partial(8'h3D, 3, HALF);
        rst_n = 1'b0;
        tick(5);
        rst_n = 1'b1;
        tick(GAP);
        check_state("mid_rst", 12'h000, 1'b0);
        check("mid_rst_data", 32'(DataIN), 32'h00);
        key(8'h3D);
        check_state("post_mid_rst", 12'h000, 1'b1);
        check("post_mid_rst_data", 32'(DataIN), 32'h70);

        tick(GAP);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
